// File: rtl/bp_pkg.sv
// bp_pkg: shared helpers for the dynamic branch predictor.
//   - Counter-state encodings, derived from a counter width:
//       strong-NT = 0, weak-NT = 0111.., weak-T = 1000.., strong-T = 1111..
//   - pc_index / pc_tag : split a fetch or branch PC into table index and tag.
//   - sat_inc / sat_dec : saturating counter steps.
// The helpers work on fixed maximum-width vectors plus a width argument, so one
// package serves every parameterisation. Callers zero-extend their inputs and
// truncate the results to their own widths.
package bp_pkg;

  localparam int MAX_PC_BITS  = 64;
  localparam int MAX_CTR_BITS = 8;

  typedef logic [MAX_PC_BITS-1:0]  pc_t;
  typedef logic [MAX_CTR_BITS-1:0] ctr_t;

  localparam ctr_t CTR_STRONG_NT = '0;

  function automatic ctr_t ctr_strong_taken(input int bits);
    return (ctr_t'(1) << bits) - ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_weak_taken(input int bits);
    return ctr_t'(1) << (bits - 1);
  endfunction

  function automatic ctr_t ctr_weak_not_taken(input int bits);
    return ctr_weak_taken(bits) - ctr_t'(1);
  endfunction

  function automatic ctr_t sat_inc(input ctr_t ctr, input int bits);
    return (ctr == ctr_strong_taken(bits)) ? ctr : ctr + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t ctr);
    return (ctr == CTR_STRONG_NT) ? ctr : ctr - ctr_t'(1);
  endfunction

  // Word-aligned index: pc[index_bits+1:2]; pc[1:0] never takes part.
  function automatic pc_t pc_index(input pc_t pc, input int index_bits);
    return (pc >> 2) & ((pc_t'(1) << index_bits) - pc_t'(1));
  endfunction

  // Everything above the index bits.
  function automatic pc_t pc_tag(input pc_t pc, input int index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: array of saturating direction counters.
//   clk, rst_n : clock, asynchronous active-low reset (all counters -> weak-NT)
//   rd_idx     : combinational read index; rd_ctr returns that counter
//   wr_en      : apply an update at the clock edge to wr_idx
//   wr_alloc   : load weak-taken (new BTB entry) instead of stepping
//   wr_taken   : step direction when not allocating (inc on 1, dec on 0)
// Reads see state before any same-cycle write (no bypass).
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_alloc,
  input  logic                  wr_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(ctr_weak_taken(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_reg [ENTRIES];
  logic [CTR_BITS-1:0] wr_old;
  logic [CTR_BITS-1:0] wr_next;

  assign rd_ctr = ctr_reg[rd_idx];
  assign wr_old = ctr_reg[wr_idx];

  always_comb begin
    wr_next = wr_old;
    if (wr_alloc)
      wr_next = WEAK_T;
    else if (wr_taken)
      wr_next = CTR_BITS'(sat_inc(ctr_t'(wr_old), CTR_BITS));
    else
      wr_next = CTR_BITS'(sat_dec(ctr_t'(wr_old)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= WEAK_NT;
    end else if (wr_en) begin
      ctr_reg[wr_idx] <= wr_next;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + saturating-counter direction predictor for the RV32 core.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bp_enable        : 1 = use predictions, 0 = always predict not-taken
//   if_pc            : fetch PC; pred_hit / pred_taken / pred_target answer it
//                      combinationally in the same cycle
//   upd_valid/_pc/_taken/_target/_mispred : resolved outcome from EX, applied
//                      at the clock edge (training ignores bp_enable)
//   stat_branches    : number of updates seen, wraps mod 2^32
//   stat_mispreds    : number of updates flagged as mispredicted
// Optional feature, macro BP_GSHARE_EN: counter index = pc index XOR global
// history (HIST_BITS). BTB valid/tag/target stay PC-indexed. Undefined: bimodal.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bp_enable,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_hit,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispred,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispreds
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;

  logic                valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [PC_WIDTH-1:0] target_reg [ENTRIES];
  logic [31:0]         branches_reg;
  logic [31:0]         mispreds_reg;

  logic [INDEX_BITS-1:0] lk_idx, up_idx, lk_ctr_idx, up_ctr_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  up_hit, up_alloc;
  logic [CTR_BITS-1:0]   lk_ctr;

  assign lk_idx = INDEX_BITS'(pc_index(MAX_PC_BITS'(if_pc), INDEX_BITS));
  assign up_idx = INDEX_BITS'(pc_index(MAX_PC_BITS'(upd_pc), INDEX_BITS));
  assign lk_tag = TAG_BITS'(pc_tag(MAX_PC_BITS'(if_pc), INDEX_BITS));
  assign up_tag = TAG_BITS'(pc_tag(MAX_PC_BITS'(upd_pc), INDEX_BITS));

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_reg;

  // Both ports use the history as it stands this cycle; for the update that is
  // the history before its own outcome is shifted in.
  assign lk_ctr_idx = lk_idx ^ INDEX_BITS'(ghr_reg);
  assign up_ctr_idx = up_idx ^ INDEX_BITS'(ghr_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr_reg <= '0;
    else if (upd_valid)
      ghr_reg <= HIST_BITS'({ghr_reg, upd_taken});
  end
`else
  assign lk_ctr_idx = lk_idx;
  assign up_ctr_idx = up_idx;
`endif

  // Lookup: pure function of if_pc and current state.
  assign pred_hit    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign pred_taken  = bp_enable && pred_hit && lk_ctr[CTR_BITS-1];
  assign pred_target = pred_hit ? target_reg[lk_idx] : if_pc + PC_WIDTH'(4);

  // Update: hits train the counter; misses allocate only when taken.
  assign up_hit   = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
  assign up_alloc = !up_hit && upd_taken;

  bp_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_BITS   (CTR_BITS)
  ) u_ctr_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (lk_ctr_idx),
    .rd_ctr   (lk_ctr),
    .wr_en    (upd_valid && (up_hit || up_alloc)),
    .wr_idx   (up_ctr_idx),
    .wr_alloc (up_alloc),
    .wr_taken (upd_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      // Taken outcome: allocate on miss, refresh target on hit.
      valid_reg[up_idx]  <= 1'b1;
      tag_reg[up_idx]    <= up_tag;
      target_reg[up_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_reg <= '0;
      mispreds_reg <= '0;
    end else if (upd_valid) begin
      branches_reg <= branches_reg + 32'd1;
      if (upd_mispred) mispreds_reg <= mispreds_reg + 32'd1;
    end
  end

  assign stat_branches = branches_reg;
  assign stat_mispreds = mispreds_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default bimodal build; the alternating
// pattern check switches its expectation when BP_GSHARE_EN is defined).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bp_enable = 1'b1;
  logic [31:0] if_pc = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;
  logic [31:0] stat_branches, stat_mispreds;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bp_enable     (bp_enable),
    .if_pc         (if_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispred   (upd_mispred),
    .stat_branches (stat_branches),
    .stat_mispreds (stat_mispreds)
  );

  typedef struct {
    logic        do_upd;
    logic [31:0] u_pc;
    logic        u_taken;
    logic [31:0] u_target;
    logic [31:0] look_pc;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  localparam logic [31:0] PC_A = 32'h4000_0100;
  localparam logic [31:0] PC_B = 32'h4000_0200;
  localparam logic [31:0] PC_C = 32'h4000_0010;
  localparam logic [31:0] PC_G = 32'h4000_0400;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic check_lookup(input string name, input logic [31:0] pc,
                              input logic eh, input logic et, input logic [31:0] etgt);
    if_pc = pc;
    #1;
    check({name, ".hit"},    32'(pred_hit),   32'(eh));
    check({name, ".taken"},  32'(pred_taken), 32'(et));
    check({name, ".target"}, pred_target,     etgt);
  endtask

  // Drive one update for exactly one clock edge, leave bench 1 time unit after it.
  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispred = mis;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int wrong;
    logic exp_out;

    // Stimulus table: optional update, then a lookup with expected outputs.
    vecs[0]  = '{1'b1, PC_A, 1'b1, 32'h4000_0040, PC_A, 1'b1, 1'b1, 32'h4000_0040}; // alloc, ctr 10
    vecs[1]  = '{1'b1, PC_B, 1'b0, 32'h0,         PC_B, 1'b0, 1'b0, 32'h4000_0204}; // NT miss: no alloc
    vecs[2]  = '{1'b0, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b1, 32'h4000_0040}; // A untouched
    vecs[3]  = '{1'b1, PC_A, 1'b1, 32'h4000_0040, PC_A, 1'b1, 1'b1, 32'h4000_0040}; // 11
    vecs[4]  = '{1'b1, PC_A, 1'b1, 32'h4000_0040, PC_A, 1'b1, 1'b1, 32'h4000_0040}; // 11 sat
    vecs[5]  = '{1'b1, PC_A, 1'b1, 32'h4000_0040, PC_A, 1'b1, 1'b1, 32'h4000_0040}; // 11 sat
    vecs[6]  = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b1, 32'h4000_0040}; // 10 hysteresis
    vecs[7]  = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040}; // 01
    vecs[8]  = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040}; // 00
    vecs[9]  = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040}; // 00 sat
    vecs[10] = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040};
    vecs[11] = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040};
    vecs[12] = '{1'b1, PC_A, 1'b0, 32'h0,         PC_A, 1'b1, 1'b0, 32'h4000_0040};
    vecs[13] = '{1'b1, PC_A, 1'b1, 32'h4000_0040, PC_A, 1'b1, 1'b0, 32'h4000_0040}; // 01 still NT
    vecs[14] = '{1'b1, PC_B, 1'b1, 32'h4000_0080, PC_B, 1'b1, 1'b1, 32'h4000_0080}; // alias replaces
    vecs[15] = '{1'b0, PC_A, 1'b0, 32'h0,         PC_A, 1'b0, 1'b0, 32'h4000_0104}; // A evicted
    vecs[16] = '{1'b1, PC_B, 1'b1, 32'h4000_0090, PC_B, 1'b1, 1'b1, 32'h4000_0090}; // target refresh
    vecs[17] = '{1'b1, PC_C, 1'b1, 32'h4000_1000, PC_C, 1'b1, 1'b1, 32'h4000_1000}; // other index
    vecs[18] = '{1'b0, PC_A, 1'b0, 32'h0, 32'h4000_0013, 1'b1, 1'b1, 32'h4000_1000}; // pc[1:0] ignored

    // Reset asserted in the middle of a pending update, held across an edge.
    rst_n = 1'b1;
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = PC_A; upd_taken = 1'b1; upd_target = 32'h4000_0040; upd_mispred = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispred = 1'b0;
    check_lookup("in_reset", 32'h4000_0010, 1'b0, 1'b0, 32'h4000_0014);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_lookup("post_reset", 32'h4000_0010, 1'b0, 1'b0, 32'h4000_0014);
    check_lookup("post_reset_a", PC_A, 1'b0, 1'b0, 32'h4000_0104);
    check("reset.stat_branches", stat_branches, 32'd0);
    check("reset.stat_mispreds", stat_mispreds, 32'd0);

    // Table-driven main function.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (vecs[i].do_upd)
        do_update(vecs[i].u_pc, vecs[i].u_taken, vecs[i].u_target, 1'b0);
      check_lookup($sformatf("vec%0d", i), vecs[i].look_pc,
                   vecs[i].exp_hit, vecs[i].exp_taken, vecs[i].exp_target);
    end

    // Enable gating: trained entry, predictions suppressed; training continues.
    @(negedge clk);
    bp_enable = 1'b0;
    check_lookup("gate_b", PC_B, 1'b1, 1'b0, 32'h4000_0090);
    @(negedge clk); do_update(PC_C, 1'b0, 32'h0, 1'b0);   // 10 -> 01
    @(negedge clk); do_update(PC_C, 1'b0, 32'h0, 1'b0);   // 01 -> 00
    bp_enable = 1'b1;
    check_lookup("gate_trained_c", PC_C, 1'b1, 1'b0, 32'h4000_1000);
    @(negedge clk); do_update(PC_C, 1'b1, 32'h4000_1000, 1'b0); // 00 -> 01

    // Same-cycle lookup and update of the same PC: old counter visible.
    @(negedge clk);
    if_pc = PC_C;
    upd_valid = 1'b1; upd_pc = PC_C; upd_taken = 1'b1; upd_target = 32'h4000_1000;
    #1;
    check("conflict.pre_taken", 32'(pred_taken), 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check("conflict.post_taken", 32'(pred_taken), 32'd1);

    // Statistics: 10 updates, 3 flagged mispredicted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      do_update(32'h4000_1000 + 32'(i * 4), i[0], 32'h4000_2000, (i == 1 || i == 4 || i == 8));
    end
    check("stats.branches", stat_branches, 32'd10);
    check("stats.mispreds", stat_mispreds, 32'd3);

    // Alternating T/NT at one PC: count wrong predictions after warm-up.
    do_reset();
    wrong = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if_pc = PC_G;
      exp_out = (i % 2 == 0);
      #1;
      if (i >= 8 && pred_taken != exp_out) wrong++;
      do_update(PC_G, exp_out, 32'h4000_0800, 1'b0);
    end
`ifdef BP_GSHARE_EN
    check("alt_pattern.wrong_gshare", 32'(wrong), 32'd0);
`else
    // Bimodal flips between weak-T and weak-NT and is always one step behind.
    check("alt_pattern.wrong_bimodal", 32'(wrong), 32'd16);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the 5-stage RV32 core.
- IF stage queries it with the fetch PC each cycle and receives a taken/target prediction in the same cycle.
- EX stage trains it with resolved branch and jump outcomes.
- Replaces the fixed predict-not-taken behaviour gated by bp_enable. Table depth and counter width are generic, and the block keeps branch and mispredict statistics for CSR readout.

Parameters:
PC_WIDTH, 32, fetch/branch address width.
INDEX_BITS, 6, log2 of table entries (64 entries).
CTR_BITS, 2, saturating direction counter width (≥1).
HIST_BITS, 6, global history length (used only with BP_GSHARE_EN; ≤ INDEX_BITS).

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
bp_enable  in  1  1 = use predictions; 0 = force not-taken.
if_pc  in  PC_WIDTH  fetch PC to predict.
pred_hit  out  1  BTB tag match and entry valid.
pred_taken  out  1  predict redirect.
pred_target  out  PC_WIDTH  predicted target.
upd_valid  in  1  resolved control-flow instruction in EX this cycle.
upd_pc  in  PC_WIDTH  PC of that instruction.
upd_taken  in  1  actual direction.
upd_target  in  PC_WIDTH  actual target (ALU result).
upd_mispred  in  1  prediction carried down the pipe was wrong.
stat_branches  out  32  count of upd_valid events.
stat_mispreds  out  32  count of upd_valid && upd_mispred.

Behaviour:
- Indexing:
  - idx = pc[INDEX_BITS+1:2].
  - tag = pc[PC_WIDTH-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target, and a CTR_BITS counter.
- Lookup is combinational from the register array (zero latency). Outputs are a function of if_pc and the current state only.
  - pred_hit = valid[idx] && tag match.
  - pred_taken = bp_enable && pred_hit && ctr MSB.
  - pred_target = stored target on hit, else if_pc+4.
- Update takes effect at the clock edge when upd_valid=1.
  - Tag miss: allocate the entry only if upd_taken=1. Allocation writes valid=1, tag, target, and ctr=weakly-taken (MSB=1, rest 0). Not-taken misses are not allocated.
  - Tag hit: ctr increments on taken and decrements on not-taken, saturating at all-ones and at 0. Target is overwritten when upd_taken=1.
- Training is independent of bp_enable: the table learns while prediction is disabled.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value. There is no bypass.
- Stats counters increment on the update edge and wrap modulo 2^32.
- Reset (asynchronous, any cycle, including mid-update):
  - all valid=0;
  - counters = weakly-not-taken (MSB=0, rest 1);
  - targets and tags = 0;
  - stats = 0;
  - history = 0.
- Outputs during and after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- No state machine: per-entry counters act as the FSM. States for CTR_BITS=2: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Optional Feature:
BP_GSHARE_EN.
- Defined:
  - A HIST_BITS global history register shifts in upd_taken on every upd_valid.
  - The counter index becomes idx XOR (ghr zero-extended).
  - BTB valid/tag/target stay PC-indexed.
  - The lookup uses the current ghr; the update uses the ghr before its own shift.
  - The history resets to 0.
- Undefined:
  - Pure bimodal indexing.
  - No history register is synthesised; HIST_BITS is ignored.

Decomposition:
- Package bp_pkg:
  - counter-state localparams (strong/weak NT/T encodings derived from CTR_BITS);
  - functions pc_index(pc) and pc_tag(pc);
  - sat_inc / sat_dec functions.
- One natural sub-module, bp_counter_table: an array of CTR_BITS counters with async reset, a combinational read port, and a saturating update port. Shared by bimodal and gshare indexing.

Test Plan:
- Reset check: assert rst_n=0 mid-update, then release. For if_pc=0x4000_0010, require pred_hit=0, pred_taken=0, pred_target=0x4000_0014, and both stats=0.
- Allocation: one update with pc=0x4000_0100, taken, target 0x4000_0040. The next cycle's lookup of 0x4000_0100 requires hit=1, taken=1, target=0x4000_0040. A not-taken update to 0x4000_0200 must leave that lookup at hit=0.
- Saturation/hysteresis: after 4 taken updates, 1 not-taken update keeps pred_taken=1, and a 2nd not-taken gives 0. 5 further not-taken updates followed by 1 taken must leave pred_taken=0.
- Aliasing: allocate 0x4000_0100, then look up 0x4000_0200 (same idx, different tag). Require hit=0 and target=0x4000_0204. A taken update to 0x4000_0200 replaces the entry, so 0x4000_0100 then misses.
- Enable gating and same-cycle conflict: with bp_enable=0 and a trained entry, pred_taken=0 while pred_hit=1. Updating and looking up the same PC in one cycle returns the old counter.
- Statistics and gshare: 10 updates with 3 mispredicts give stat_branches=10 and stat_mispreds=3. With BP_GSHARE_EN, an alternating T/NT pattern at one PC reaches 100% correct prediction after warm-up; bimodal does not.
